inst_fetch_queue: RTL

//  Instruction-fetch front end upstream of decode/register read in the single-clock CPU.

---
 rtl/inst_fetch_queue_pkg.sv | 27 ++
 rtl/inst_fetch_queue_fetch_fifo.sv | 118 +++++++++++
 rtl/inst_fetch_queue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the fetch FSM state encoding, datapath widths, the PC step and the
// {pc, inst} queue entry layout used by the top and its fetch FIFO.
package inst_fetch_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fs_state_e;

  // Queue entry: PC in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are word aligned; the two byte-offset bits are discarded.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Small FIFO of fetched {pc, inst} entries feeding decode.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         empty the queue at the next edge (wins over push/pop)
//   push_i          append push_data_i at the tail
//   push_data_i     entry to append
//   pop_i           drop the head entry (ignored while empty)
//   count_o         number of valid entries
//   valid_o         registered "queue not empty"
//   head_o          registered copy of the head entry (holds while empty)
module inst_fetch_queue_fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       valid_o,
  output fetch_entry_t               head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  fetch_entry_t     head_q, head_d;
  logic             pop_en_s;
  logic             push_en_s;

  // Pointer, count and next-head computation.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    pop_en_s  = pop_i && valid_q && !flush_i;
    push_en_s = push_i && !flush_i && ((count_q != FULL_CNT) || pop_en_s);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // The next head either already sits in the array or is the entry being
      // written this very cycle (queue empty, or draining its last entry).
      if (count_d != '0) begin
        if (push_en_s && (wr_ptr_q == rd_ptr_d)) begin
          head_d = push_data_i;
        end else begin
          head_d = mem_q[rd_ptr_d];
        end
      end else begin
        head_d = head_q;
      end
    end
    valid_d = (count_d != '0);
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_en_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives a synchronous-read
// instruction memory (one-cycle latency) and queues fetched words for decode.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr_o       instruction memory index (low ADDR_W bits of the byte PC)
//   imem_en_o         read request this cycle; data arrives next cycle
//   imem_data_i       read data for last cycle's request
//   redirect_i        flush all queued/in-flight fetches, restart at redirect_pc_i
//   redirect_pc_i     new PC (byte offset bits ignored)
//   id_valid_o        id_inst_o/id_pc_o hold a valid instruction
//   id_ready_i        decode takes the head when id_valid_o & id_ready_i
//   id_inst_o         instruction at queue head
//   id_pc_o           byte PC of id_inst_o
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 8,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_en_o,
  input  logic [INST_W-1:0] imem_data_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [INST_W-1:0] id_inst_o,
  output logic [PC_W-1:0]   id_pc_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  fs_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0] count_s;
  logic [OCC_W-1:0] occupancy_s;
  logic             credit_ok_s;
  logic             issue_s;
  logic             flush_s;
  logic             pop_s;
  fetch_entry_t     push_entry_s;
  fetch_entry_t     head_s;

  // A request is only issued when a queue slot is guaranteed for its data,
  // counting the word that may still be on its way back from memory.
  assign occupancy_s = OCC_W'(count_s) + OCC_W'(inflight_q);
  assign credit_ok_s = (occupancy_s < DEPTH_OCC);

  // Fetch FSM, PC sequencing and request issue.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    issue_s       = 1'b0;
    flush_s       = 1'b0;
    case (state_q)
      FS_IDLE: begin
        state_d = FS_RUN;
      end
      FS_RUN, FS_FLUSH: begin
        if (redirect_i) begin
          flush_s = 1'b1;
          pc_d    = align_pc(redirect_pc_i);
          state_d = FS_FLUSH;
        end else begin
          state_d = FS_RUN;
          if (credit_ok_s) begin
            issue_s       = 1'b1;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + PC_STEP;
          end else begin
            pc_d = pc_q;
          end
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // FSM, PC and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Returning data is tagged with the PC it was fetched from; a redirect in
  // the same cycle discards it through the FIFO flush.
  assign push_entry_s = {inflight_pc_q, imem_data_i};
  assign pop_s        = id_ready_i && !redirect_i;

  inst_fetch_queue_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_s),
    .push_i      (inflight_q),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .valid_o     (id_valid_o),
    .head_o      (head_s)
  );

  assign imem_en_o   = issue_s;
  assign imem_addr_o = pc_q[ADDR_W-1:0];
  assign id_inst_o   = head_s.inst;
  assign id_pc_o     = head_s.pc;

endmodule
